// File: rtl/ds1302_pkg.sv
// Shared types and constants for the DS1302 3-wire serial transactors.
package ds1302_pkg;

    // Transactor states shared by the write (and future read) FSMs.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_CMD  = 2'd1,
        SEND_DATA = 2'd2,
        DONE      = 2'd3
    } ds1302_state_e;

    // One full write frame is a command byte followed by a data byte.
    localparam int DS1302_BITS = 16;
    localparam int CMD_BITS    = 8;

    // Frequently used command bytes (bit0 = 0 selects a write).
    localparam logic [7:0] WP_ADDR      = 8'h8E;
    localparam logic [7:0] SECONDS_ADDR = 8'h80;
    localparam logic [7:0] TCS_ADDR     = 8'h90;

    // Turns any command byte into a legal write command:
    // bit7 must be 1 for a valid command, bit0 = 0 selects write.
    function automatic logic [7:0] force_write_cmd(input logic [7:0] cmd);
        return {1'b1, cmd[6:1], 1'b0};
    endfunction

endpackage

// File: rtl/ds1302_sclk_edge.sv
// Resynchronises the externally generated sclk into the clk domain and
// produces single-cycle rise/fall pulses from the last two synced samples.
// SYNC_STAGES must be at least 2.
module ds1302_sclk_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    output logic sclk_sync,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   prev_d, prev_q;

    // Shift the raw sclk into the synchroniser; keep the previous synced sample.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sclk};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history flops, cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge pulses last exactly one clk because prev_q follows sync_q.
    always_comb begin
        sclk_sync = sync_q[SYNC_STAGES-1];
        sclk_rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
        sclk_fall = ~sync_q[SYNC_STAGES-1] &  prev_q;
    end

endmodule

// File: rtl/ds1302_write.sv
// Single-byte DS1302 write transactor: shifts {dataIn, addr} out LSB-first,
// changing dataOut only after sclk falls so each bit is stable across the
// following rising edge where the RTC samples it.
// Optional build macro DS1302_WRITE_CMD_FORCE_EN: when defined, the latched
// command byte is forced to a write command ({1, addr[6:1], 0}).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for en; done holds the last completion
// SEND_CMD  | shifting command bits 0..7, one per detected sclk fall
// SEND_DATA | shifting data bits 0..7, one per detected sclk fall
// DONE      | frame closed (ce/ioDir low, done high); returns to IDLE
module ds1302_write
    import ds1302_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] addr,
    input  logic [7:0] dataIn,
    input  logic       sclk,
    output logic       ce,
    output logic       dataOut,
    output logic       ioDir,
    output logic       done
);

    localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
    localparam logic [3:0] DATA_LAST = 4'(DS1302_BITS - 1);

    ds1302_state_e           state_d, state_q;
    logic [DS1302_BITS-1:0]  shift_d, shift_q;
    logic [3:0]              cnt_d, cnt_q;
    logic                    ce_d, ce_q;
    logic                    dout_d, dout_q;
    logic                    iodir_d, iodir_q;
    logic                    done_d, done_q;
    logic [7:0]              cmd_byte;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic unused_ok;

    ds1302_sclk_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sclk_edge (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sclk_sync(sclk_sync),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall)
    );

    // Rising edges belong to the RTC side; the write path only acts on falls.
    assign unused_ok = sclk_sync ^ sclk_rise;

    // Command byte as it will be latched at the start of a frame.
    always_comb begin
`ifdef DS1302_WRITE_CMD_FORCE_EN
        cmd_byte = force_write_cmd(addr);
`else
        cmd_byte = addr;
`endif
    end

    // Next-state and registered-output logic for the write frame.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ce_d    = ce_q;
        dout_d  = dout_q;
        iodir_d = iodir_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    shift_d = {dataIn, cmd_byte};
                    cnt_d   = '0;
                    ce_d    = 1'b1;
                    iodir_d = 1'b1;
                    dout_d  = cmd_byte[0];
                    done_d  = 1'b0;
                    state_d = SEND_CMD;
                end
            end

            SEND_CMD, SEND_DATA: begin
                if (sclk_fall) begin
                    shift_d = shift_q >> 1;
                    dout_d  = shift_q[1];
                    cnt_d   = cnt_q + 4'd1;
                    if (state_q == SEND_CMD && cnt_q == CMD_LAST) begin
                        state_d = SEND_DATA;
                    end
                    if (state_q == SEND_DATA && cnt_q == DATA_LAST) begin
                        // Close the frame on the same edge that enters DONE.
                        cnt_d   = '0;
                        ce_d    = 1'b0;
                        iodir_d = 1'b0;
                        dout_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                ce_d    = 1'b0;
                iodir_d = 1'b0;
                dout_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame with no done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            dout_q  <= 1'b0;
            iodir_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            dout_q  <= dout_d;
            iodir_q <= iodir_d;
            done_q  <= done_d;
        end
    end

    // Drive ports straight from flops so the pad sees glitch-free levels.
    always_comb begin
        ce      = ce_q;
        dataOut = dout_q;
        ioDir   = iodir_q;
        done    = done_q;
    end

endmodule

// File: tb/tb_ds1302_write.sv
// Directed bench for ds1302_write: checks reset, bit streams sampled at
// sclk rises, completion latency, busy-en rejection and mid-frame reset.
module tb_ds1302_write;

    // sclk half period in clk cycles; must exceed the fall-detect latency.
    localparam int H = 6;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] addr;
    logic [7:0] dataIn;
    logic       sclk;
    logic       ce;
    logic       dataOut;
    logic       ioDir;
    logic       done;

    int tests_run;
    int tests_failed;
    int done_rises;
    logic done_prev;

    ds1302_write #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .addr   (addr),
        .dataIn (dataIn),
        .sclk   (sclk),
        .ce     (ce),
        .dataOut(dataOut),
        .ioDir  (ioDir),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done rising edges to prove a single completion per frame.
    initial begin
        done_rises = 0;
        done_prev  = 1'b0;
    end
    always @(posedge clk) begin
        if (done === 1'b1 && done_prev !== 1'b1) done_rises++;
        done_prev = done;
    end

    // One full sclk pulse with the data sampled at the rising edge.
    task automatic sclk_pulse(output logic bit_at_rise, output logic ce_at_rise);
        @(negedge clk);
        sclk = 1'b1;
        bit_at_rise = dataOut;
        ce_at_rise  = ce;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    // Full write frame; optionally re-pulses en with other bytes mid-frame.
    task automatic write_xfer(input logic [7:0] a, input logic [7:0] d,
                              input logic [15:0] exp_stream, input string name,
                              input int mid_en_at);
        logic [15:0] got;
        logic        b, c;
        logic        ce_ok;
        int          rises0;
        got    = '0;
        ce_ok  = 1'b1;
        rises0 = done_rises;

        @(negedge clk);
        addr = a; dataIn = d; en = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (ce !== 1'b1 || ioDir !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_start: ce=%b ioDir=%b done=%b, required ce=1 ioDir=1 done=0",
                     name, ce, ioDir, done);
        end
        @(negedge clk);
        en = 1'b0;

        for (int i = 0; i < 15; i++) begin
            sclk_pulse(b, c);
            got[i] = b;
            if (c !== 1'b1) ce_ok = 1'b0;
            if (i == mid_en_at) begin
                en = 1'b1; addr = 8'h12; dataIn = 8'hFF;
                @(negedge clk);
                en = 1'b0;
            end
        end

        // Last pulse: measure the fall-to-done latency (SYNC_STAGES+1 clk).
        @(negedge clk);
        sclk = 1'b1;
        got[15] = dataOut;
        if (ce !== 1'b1) ce_ok = 1'b0;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || ce !== 1'b1 || ioDir !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_pre_done: done=%b ce=%b ioDir=%b, required done=0 ce=1 ioDir=1",
                     name, done, ce, ioDir);
        end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b1 || ce !== 1'b0 || ioDir !== 1'b0 || dataOut !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: done=%b ce=%b ioDir=%b dataOut=%b, required 1 0 0 0",
                     name, done, ce, ioDir, dataOut);
        end
        repeat (H) @(negedge clk);

        tests_run++;
        if (got !== exp_stream) begin
            tests_failed++;
            $display("FAIL %s_stream: got %h, required %h", name, got, exp_stream);
        end
        tests_run++;
        if (ce_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ce_held: ce dropped during frame, required ce=1 at every rise", name);
        end
        tests_run++;
        if (done_rises - rises0 != 1) begin
            tests_failed++;
            $display("FAIL %s_done_once: %0d done rises, required 1", name, done_rises - rises0);
        end
    endtask

    task automatic test_reset;
        logic b, c;
        logic quiet;
        quiet = 1'b1;
        rst = 1'b0; en = 1'b0; addr = '0; dataIn = '0; sclk = 1'b0;
        #1;
        tests_run++;
        if (ce !== 1'b0 || ioDir !== 1'b0 || done !== 1'b0 || dataOut !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: ce=%b ioDir=%b done=%b dataOut=%b, required all 0",
                     ce, ioDir, done, dataOut);
        end
        for (int i = 0; i < 3; i++) begin
            sclk_pulse(b, c);
            if (b !== 1'b0 || c !== 1'b0 || ioDir !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk_pulse(b, c);
            if (b !== 1'b0 || c !== 1'b0 || ioDir !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (quiet !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_idle_sclk: outputs moved with sclk toggling, required all 0");
        end
    endtask

    task automatic test_wp_write;
        logic b, c;
        logic stay;
        stay = 1'b1;
        write_xfer(8'h8E, 8'h00, 16'h008E, "wp", -1);
        for (int i = 0; i < 16; i++) begin
            sclk_pulse(b, c);
            if (done !== 1'b1 || c !== 1'b0 || b !== 1'b0 || ioDir !== 1'b0) stay = 1'b0;
        end
        tests_run++;
        if (stay !== 1'b1) begin
            tests_failed++;
            $display("FAIL wp_extra_pulses: done=%b ce=%b, required done held 1 and ce 0", done, ce);
        end
    endtask

    task automatic test_pattern;
        write_xfer(8'hA5, 8'h3C, 16'h3CA5, "a5_3c", -1);
    endtask

    task automatic test_busy_en;
        write_xfer(8'hC3, 8'h81, 16'h81C3, "busy_en", 3);
    endtask

    task automatic test_reset_mid;
        logic b, c;
        @(negedge clk);
        addr = 8'h8E; dataIn = 8'h55; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) sclk_pulse(b, c);
        rst = 1'b0;
        #1;
        tests_run++;
        if (ce !== 1'b0 || ioDir !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_abort: ce=%b ioDir=%b done=%b, required 0 0 0", ce, ioDir, done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (H) @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || ce !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: done=%b ce=%b, required 0 0", done, ce);
        end
        write_xfer(8'hA5, 8'h3C, 16'h3CA5, "restart", -1);
    endtask

    task automatic test_cmd_force;
`ifdef DS1302_WRITE_CMD_FORCE_EN
        write_xfer(8'h0F, 8'h5A, 16'h5A8E, "cmd_force", -1);
`else
        write_xfer(8'h0F, 8'h5A, 16'h5A0F, "cmd_verbatim", -1);
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_wp_write();
        test_pattern();
        test_busy_en();
        test_reset_mid();
        test_cmd_force();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
